// File: rtl/cla_nibble_sequencer_if.sv
// Handshake, operand/result and CLA-pin bundle for cla_nibble_sequencer.
// The sequencer takes the slave side; whatever drives operands, consumes
// results and hosts the 4-bit CLA takes the master side.
interface cla_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_sub;

    logic [3:0]       cla_a;
    logic [3:0]       cla_b;
    logic             cla_cin;
    logic [3:0]       cla_s;
    logic             cla_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub,
        input  cla_s, cla_cout,
        input  out_ready,
        output in_ready,
        output cla_a, cla_b, cla_cin,
        output out_valid, sum, carry_out, overflow, busy
    );

    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub,
        output cla_s, cla_cout,
        output out_ready,
        input  in_ready,
        input  cla_a, cla_b, cla_cin,
        input  out_valid, sum, carry_out, overflow, busy
    );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Wide add/subtract built around an external combinational 4-bit CLA.
// Operands are accepted on a valid/ready handshake, fed to the CLA one
// nibble per cycle (LSB first) with the carry chained through a register,
// and the reassembled result is offered on an output valid/ready handshake.
// WIDTH must be a multiple of 4 and at least 8.
module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    cla_nibble_sequencer_if.slave   bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              a_msb_q;
    logic              b_msb_q;
    logic [WIDTH-5:0]  acc_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_out_q;
    logic              overflow_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [WIDTH-1:0]  b_eff_d;
    logic [WIDTH-1:0]  sum_d;
    logic              overflow_d;

    // Effective B: inverted for subtract (A + ~B + 1).
    assign b_eff_d    = bus.op_sub ? ~bus.op_b : bus.op_b;
    // Full result as it stands once the current nibble is appended at the top.
    assign sum_d      = {bus.cla_s, acc_q};
    assign overflow_d = (a_msb_q == b_msb_q) & (bus.cla_s[3] != a_msb_q);

    // Sequencer FSM: accept, nibble-serial run through the CLA, hold result.
    // Operand registers shift right one nibble per RUN cycle so the CLA pins
    // come straight from the low nibble and fall to zero once the last nibble
    // is consumed; the operand sign bits are kept aside for overflow.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.op_a;
                        b_q        <= b_eff_d;
                        a_msb_q    <= bus.op_a[WIDTH-1];
                        b_msb_q    <= b_eff_d[WIDTH-1];
                        carry_q    <= bus.op_sub ? 1'b1 : bus.op_cin;
                        idx_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    acc_q <= sum_d[WIDTH-1:4];
                    if (idx_q == IW'(NIB - 1)) begin
                        idx_q       <= '0;
                        carry_q     <= 1'b0;
                        sum_q       <= sum_d;
                        carry_out_q <= bus.cla_cout;
                        overflow_q  <= overflow_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        carry_q <= bus.cla_cout;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.cla_a     = a_q[3:0];
    assign bus.cla_b     = b_q[3:0];
    assign bus.cla_cin   = carry_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench for cla_nibble_sequencer (WIDTH=16) with a behavioural
// 4-bit CLA on the pins and an arithmetic reference model of the sequencer.
module tb_cla_nibble_sequencer;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_nibble_sequencer_if #(.WIDTH(W)) bus();

    cla_nibble_sequencer #(.WIDTH(W)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus)
    );

    // Behavioural 4-bit CLA.
    logic [4:0] cla_tot;
    assign cla_tot      = {1'b0, bus.cla_a} + {1'b0, bus.cla_b} + {4'b0, bus.cla_cin};
    assign bus.cla_s    = cla_tot[3:0];
    assign bus.cla_cout = cla_tot[4];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from integer add/subtract.
    task automatic ref_result(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic sub, output logic [15:0] s, output logic co,
                              output logic ov);
        int          sres;
        int unsigned ures;
        logic [31:0] t;
        if (sub) begin
            sres = int'($signed(a)) - int'($signed(b));
            t    = 32'(int'(a) - int'(b));
            co   = (a >= b);
        end else begin
            sres = int'($signed(a)) + int'($signed(b)) + int'(cin);
            ures = 32'(a) + 32'(b) + 32'(cin);
            t    = ures;
            co   = (ures > 32'h0000_FFFF);
        end
        s  = t[15:0];
        ov = (sres > 32767) || (sres < -32768);
    endtask

    // Carry into nibble k: carry out of the low 4k bits of a + beff + c0.
    function automatic logic exp_cin(input logic [15:0] a, input logic [15:0] beff,
                                     input logic c0, input int k);
        int unsigned mask;
        int unsigned t;
        if (k == 0) return c0;
        mask = (32'd1 << (4 * k)) - 32'd1;
        t    = (32'(a) & mask) + (32'(beff) & mask) + 32'(c0);
        return (t >> (4 * k)) != 0;
    endfunction

    // Phase model: 0 idle, 1 run (nibble m_k), 2 result offered.
    int         m_phase = 0;
    int         m_k     = 0;
    logic [15:0] m_a    = '0;
    logic [15:0] m_beff = '0;
    logic        m_c0   = 1'b0;
    logic [15:0] p_sum  = '0;
    logic        p_co   = 1'b0;
    logic        p_ov   = 1'b0;
    logic [15:0] r_sum  = '0;
    logic        r_co   = 1'b0;
    logic        r_ov   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_k     = 0;
            r_sum   = '0;
            r_co    = 1'b0;
            r_ov    = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_a    = bus.op_a;
                    m_beff = bus.op_sub ? ~bus.op_b : bus.op_b;
                    m_c0   = bus.op_sub ? 1'b1 : bus.op_cin;
                    ref_result(bus.op_a, bus.op_b, bus.op_cin, bus.op_sub, p_sum, p_co, p_ov);
                    m_k     = 0;
                    m_phase = 1;
                end
                1: begin
                    m_k++;
                    if (m_k == NIB) begin
                        m_k     = 0;
                        m_phase = 2;
                        r_sum   = p_sum;
                        r_co    = p_co;
                        r_ov    = p_ov;
                    end
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [3:0] ea;
        logic [3:0] eb;
        logic       ec;
        if (rst_n) begin
            ea = '0;
            eb = '0;
            ec = 1'b0;
            if (m_phase == 1) begin
                ea = 4'((m_a >> (4 * m_k)) & 16'hF);
                eb = 4'((m_beff >> (4 * m_k)) & 16'hF);
                ec = exp_cin(m_a, m_beff, m_c0, m_k);
            end
            check("in_ready",  32'(bus.in_ready),  32'(m_phase == 0));
            check("busy",      32'(bus.busy),      32'(m_phase != 0));
            check("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
            check("cla_a",     32'(bus.cla_a),     32'(ea));
            check("cla_b",     32'(bus.cla_b),     32'(eb));
            check("cla_cin",   32'(bus.cla_cin),   32'(ec));
            check("sum",       32'(bus.sum),       32'(r_sum));
            check("carry_out", 32'(bus.carry_out), 32'(r_co));
            check("overflow",  32'(bus.overflow),  32'(r_ov));
        end
    end

    // One operation; called at posedge+1 with the DUT idle. spam keeps
    // in_valid high (with junk operands) through RUN, DONE and the handoff edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input int hold, input bit spam,
                          output logic [15:0] s, output logic co, output logic ov,
                          output int lat, output logic [3:0] cseq);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
        bus.op_sub   = sub;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = spam;
        bus.op_a     = 16'($urandom);
        bus.op_b     = 16'($urandom);
        bus.op_cin   = 1'($urandom);
        bus.op_sub   = 1'($urandom);
        lat  = 0;
        cseq = '0;
        while (!bus.out_valid && lat < 20) begin
            if (lat < 4) cseq[lat] = bus.cla_cin;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        s  = bus.sum;
        co = bus.carry_out;
        ov = bus.overflow;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[6] = '{
        '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0}
    };

    initial begin
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        logic [3:0]  cseq;

        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_cin    = 1'b0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cla_a",     32'(bus.cla_a),     32'd0);
        check("rst_cla_cin",   32'(bus.cla_cin),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with literal expectations.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, (i == 2) ? 5 : 0,
                   (i == 2), s, co, ov, lat, cseq);
            check("vec_sum",      32'(s),   32'(vecs[i].s));
            check("vec_carry",    32'(co),  32'(vecs[i].co));
            check("vec_overflow", 32'(ov),  32'(vecs[i].ov));
            check("vec_latency",  32'(lat), 32'(NIB));
            if (i == 0) check("cin_seq_nocarry", 32'(cseq), 32'h0);
            if (i == 1) check("cin_seq_chain",   32'(cseq), 32'hE);
        end

        // Randomized operations with random back-pressure and idle gaps.
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                   s, co, ov, lat, cseq);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset during the second RUN cycle.
        bus.op_a     = 16'h1234;
        bus.op_b     = 16'h1111;
        bus.op_cin   = 1'b0;
        bus.op_sub   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_cla_a",     32'(bus.cla_a),     32'd0);
        check("abort_cla_b",     32'(bus.cla_b),     32'd0);
        check("abort_cla_cin",   32'(bus.cla_cin),   32'd0);
        check("abort_sum",       32'(bus.sum),       32'd0);
        check("abort_carry",     32'(bus.carry_out), 32'd0);
        check("abort_overflow",  32'(bus.overflow),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0, s, co, ov, lat, cseq);
        check("post_reset_sum",   32'(s),   32'h0002);
        check("post_reset_carry", 32'(co),  32'd0);
        check("post_reset_lat",   32'(lat), 32'(NIB));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cla_nibble_sequencer.md
Name: cla_nibble_sequencer

Overview:
- Upstream/downstream companion to the 4-bit `cla` adder in the user project area.
- Accepts WIDTH-bit operands over a valid/ready handshake and slices them into 4-bit nibbles.
- Drives one nibble per cycle into the external combinational CLA, LSB first, and chains the carry through a register.
- Reassembles sum, carry-out and signed overflow, then presents the result on an output valid/ready handshake. This lets the fixed 4-bit adder perform wide add and subtract.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count (localparam, not overridable).

Ports:
- wb_clk_i  input  1  clock; all state changes on the rising edge.
- wb_rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept operands.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_cin  input  1  carry-in for add; ignored when op_sub=1.
- op_sub  input  1  1 = compute A - B.
- cla_a  output  4  nibble of A to the CLA.
- cla_b  output  4  nibble of effective B to the CLA.
- cla_cin  output  1  chained carry to the CLA.
- cla_s  input  4  CLA sum, combinational from cla_a/cla_b/cla_cin.
- cla_cout  input  1  CLA carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  assembled result.
- carry_out  output  1  final carry. For subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- **States:** IDLE, RUN, DONE.
- **Reset:** async, wb_rst_n low. Takes effect immediately, including mid-RUN or mid-DONE; any in-flight operation is discarded. Reset values:
  - state = IDLE, nibble index = 0, carry reg = 0, operand regs = 0.
  - sum = 0, carry_out = 0, overflow = 0, out_valid = 0, busy = 0, in_ready = 1.
  - cla_a = 0, cla_b = 0, cla_cin = 0.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready: latch a_reg = op_a; b_reg = op_sub ? ~op_b : op_b; carry = op_sub ? 1 : op_cin; idx = 0; go to RUN.
- **RUN:**
  - in_ready = 0.
  - cla_a = a_reg[4*idx+3:4*idx]; cla_b = b_reg slice at the same position; cla_cin = carry.
  - Each edge: sum_reg slice[idx] <= cla_s; carry <= cla_cout; idx <= idx + 1.
  - At idx == NIB-1, capture as above, then go to DONE.
  - Exactly NIB RUN cycles per operation; there is no early exit on zero carry.
- **CLA drive outside RUN:** cla_a, cla_b and cla_cin are driven 0, so the CLA pins stay quiet.
- **DONE:**
  - out_valid = 1; sum, carry_out and overflow are stable, and the registered outputs hold while out_valid is high.
  - carry_out = final carry.
  - overflow = (a_reg[MSB] == b_reg[MSB]) & (sum[MSB] != a_reg[MSB]), where b_reg is the effective (possibly inverted) B.
  - On out_ready, go to IDLE. out_valid drops the next cycle. sum, carry_out and overflow keep their last values until the next DONE.
- **Timing:**
  - Latency from the accept edge to out_valid high is NIB cycles (4 for WIDTH=16).
  - Minimum issue interval is NIB+2 cycles. in_ready is low throughout RUN and DONE; there is no accept in the same cycle as result handoff.
- **Inputs during RUN/DONE:** in_valid is ignored; op_* may change freely and have no effect on the in-flight operation.
- **out_ready in IDLE/RUN:** no effect.
- **Widths:**
  - idx is clog2(NIB) bits and never wraps past NIB-1.
  - All arithmetic is performed by the external CLA; the block contains no adder.

Test Plan:
- Add 0x1234 + 0x4321, cin 0 -> sum 0x5555, carry_out 0, overflow 0. out_valid rises 4 cycles after accept; cla_cin is 0 on all 4 nibble cycles.
- Add 0xFFFF + 0x0001, cin 0 -> sum 0x0000, carry_out 1, overflow 0. cla_cin sequence is 0,1,1,1, proving the carry chain.
- Subtract 0x0005 - 0x0007 -> sum 0xFFFE, carry_out 0 (borrow), overflow 0. Subtract 0x8000 - 0x0001 -> sum 0x7FFF, overflow 1.
- Add 0x7FFF + 0x0001 -> sum 0x8000, overflow 1. Add 0x00FF + 0x0000 with cin 1 -> sum 0x0100, carry_out 0.
- Back-pressure: hold out_ready low for 5 cycles in DONE -> out_valid, sum and carry_out stable; in_ready stays 0. New in_valid is ignored until one cycle after the out_ready handshake.
- Assert wb_rst_n low at the 2nd RUN cycle -> all outputs go to reset values asynchronously. After release, the next op 0x0001 + 0x0001 yields 0x0002 with no residue from the aborted operation.
